regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath; generalises the 2-read/1-write file.
- Adds: configurable width/depth/read-port count, async active-low reset clearing, same-cycle write-to-read bypass, per-register busy scoreboard for load-use stall detection, and a sequential debug scan engine replacing simulation-only register dumps.
- Sits between decode (read ports, busy query) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NRD, 2, number of read ports (1..4)
- RSVD_REG, 24, second hardwired-zero register index; set to 0 to disable
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- raddr  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rdata  out  NRD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rbusy  out  NRD  read register i has a pending producer
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- set_busy  in  1  mark busy_addr pending (load issued)
- busy_addr  in  ADDR_W  register to mark
- dbg_start  in  1  start debug scan (pulse)
- dbg_valid  out  1  dbg_idx/dbg_data valid this cycle
- dbg_idx  out  ADDR_W  scanned register index
- dbg_data  out  DATA_W  scanned register contents
- dbg_done  out  1  one-cycle pulse after last register

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, immediate): all registers 0, all busy bits 0, scan FSM IDLE, dbg_valid/dbg_done 0, dbg_idx 0, dbg_data 0. Reset mid-scan aborts the scan with no dbg_done.
- Zero registers: index 0 and RSVD_REG (if nonzero) always read 0 and are never busy. Writes and set_busy to them are ignored.
- Write: on rising edge, if we=1 and waddr is not a zero register, reg[waddr] <= wdata. A write clears busy[waddr].
- Read (combinational, 0 latency, per port i with address a):
  - a is a zero register -> 0;
  - else BYPASS=1 and we=1 and waddr==a -> wdata;
  - else reg[a].
  - Multiple ports with the same address return identical data.
- Busy:
  - set_busy=1 sets busy[busy_addr] on the edge.
  - If set_busy and we target the same register in the same cycle, set wins: data is written and busy ends at 1.
  - rbusy[i] = busy[a] & ~(BYPASS & we & waddr==a). Zero registers report 0.
- Debug scan FSM, states IDLE, SCAN, DONE:
  - IDLE: dbg_start=1 -> SCAN with scan index 0. Otherwise stay.
  - SCAN: each edge registers dbg_valid=1, dbg_idx=index, dbg_data=stored reg[index], with zero registers shown as 0. This gives one register per cycle, output valid 1 cycle after the index is sampled. The index increments; after DEPTH-1 -> DONE.
  - DONE: dbg_valid=0, dbg_done=1 for exactly one cycle -> IDLE.
  - dbg_start is ignored outside IDLE.
  - Scan samples the pre-write value if a write to the same index lands on the same edge. Scan never stalls normal reads or writes.
  - Total: DEPTH valid cycles, then 1 done cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - scan state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - a default ZERO_REG=0 constant;
  - a function is_zero_reg(addr, rsvd).
- One sub-module is natural: regfile_dbg_scan, containing the FSM, index counter and output registers. It accesses storage through a read-index/read-data pair.
- Storage, bypass and scoreboard stay in the top module.

Test Plan:
- Reset, then read ports 0..NRD-1 at addrs 1, 31 -> rdata 0, rbusy 0. Assert rst_n=0 mid-operation -> dbg_valid and dbg_done drop immediately.
- Write 0xDEADBEEF to r5; same cycle raddr0=5 -> rdata0=0xDEADBEEF (bypass). Next cycle with we=0 -> still 0xDEADBEEF. Writes to r0 and r24 of 0x1234 -> both read 0.
- set_busy r7 -> next cycle rbusy=1 for raddr=7. Cycle with we to r7 = 0x55 -> rbusy=0 combinationally. After that edge, busy clear and rdata=0x55.
- Same-cycle set_busy r9 and write r9 = 0xAA -> after edge reg r9=0xAA, rbusy for r9 = 1. set_busy r0 -> rbusy stays 0.
- Load r1..r10 with value i*3. Pulse dbg_start -> 32 consecutive dbg_valid cycles with idx 0..31, data 0,3,...,30 then 0s. Next cycle dbg_done=1 for one cycle. A second dbg_start mid-scan is ignored.
- NRD=4, ADDR_W=4, DATA_W=16 build: four ports read r3 simultaneously -> identical data. Scan length 16, dbg_done at cycle 17 after start.

Source files
------------

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file:
//   scan_state_e  - debug scan FSM state encoding
//   ZERO_REG      - architectural hardwired-zero register index
//   is_zero_reg() - true for index 0 and for the optional reserved zero index
// -----------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  localparam int ZERO_REG = 0;

  // rsvd == 0 disables the second zero register (index 0 is always zero).
  function automatic logic is_zero_reg(input logic [31:0] addr, input logic [31:0] rsvd);
    return (addr == 32'(ZERO_REG)) || ((rsvd != '0) && (addr == rsvd));
  endfunction

endpackage

// File: rtl/regfile_dbg_scan.sv
// -----------------------------------------------------------------------------
// regfile_dbg_scan
// Sequential debug dump: walks every register index once, one per cycle, and
// presents each index/value on registered outputs, then pulses done.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         begin a scan (honoured only when idle)
//   rd_idx        index being sampled this cycle (to storage)
//   rd_data       stored value at rd_idx (zero registers already masked)
//   valid         idx/data valid this cycle
//   idx, data     scanned register index and contents
//   done          one-cycle pulse after the last register
// -----------------------------------------------------------------------------
module regfile_dbg_scan
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              valid,
  output logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  scan_state_e       state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              valid_nxt, done_nxt;
  logic [ADDR_W-1:0] idx_nxt;
  logic [DATA_W-1:0] data_nxt;

  assign rd_idx = cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_SCAN;
      ST_SCAN: if (cnt == LAST_IDX) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered: the value presented is what was sampled on the
  // edge that left the corresponding state, giving one cycle of latency.
  always_comb begin
    valid_nxt = (state == ST_SCAN);
    done_nxt  = (state == ST_DONE);
    idx_nxt   = idx;
    data_nxt  = data;
    if (state == ST_SCAN) begin
      idx_nxt  = cnt;
      data_nxt = rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
      idx   <= '0;
      data  <= '0;
    end else begin
      if (state == ST_IDLE && start) cnt <= '0;
      else if (state == ST_SCAN)     cnt <= cnt + 1'b1;
      valid <= valid_nxt;
      done  <= done_nxt;
      idx   <= idx_nxt;
      data  <= data_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Parametrised multi-read-port register file with same-cycle write bypass,
// per-register busy scoreboard for load-use stalls, and a debug scan engine.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears everything)
//   raddr/rdata/rbusy     NRD combinational read ports, port i packed at i*W
//   we/waddr/wdata        single write port
//   set_busy/busy_addr    mark a register as having a pending producer
//   dbg_start             start a full register scan
//   dbg_valid/idx/data    scan output stream
//   dbg_done              one-cycle pulse after the last scanned register
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int RSVD_REG = 24,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  set_busy,
  input  logic [ADDR_W-1:0]     busy_addr,
  input  logic                  dbg_start,
  output logic                  dbg_valid,
  output logic [ADDR_W-1:0]     dbg_idx,
  output logic [DATA_W-1:0]     dbg_data,
  output logic                  dbg_done
);

  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [31:0] RSVD   = 32'(RSVD_REG);
  localparam bit          BYP_EN = (BYPASS != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic write_ok, set_ok;
  assign write_ok = we && !is_zero_reg(32'(waddr), RSVD);
  assign set_ok   = set_busy && !is_zero_reg(32'(busy_addr), RSVD);

  // NOTE: the storage array is reset because the architecture requires all
  // registers to read 0 after reset; this prevents mapping it onto RAM macros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Set is applied after clear so a load issue and a writeback to the same
  // register on one edge leave the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (write_ok) busy[waddr]     <= 1'b0;
      if (set_ok)   busy[busy_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero, hit;
    assign a    = raddr[p*ADDR_W +: ADDR_W];
    assign zero = is_zero_reg(32'(a), RSVD);
    assign hit  = BYP_EN && we && (waddr == a);
    assign rdata[p*DATA_W +: DATA_W] = zero ? '0 : (hit ? wdata : mem[a]);
    // A write landing this cycle resolves the dependency, so no stall.
    assign rbusy[p] = !zero && busy[a] && !hit;
  end

  // The scan reads stored state only (no bypass), so it sees pre-write values.
  logic [ADDR_W-1:0] scan_idx;
  logic [DATA_W-1:0] scan_rd;
  assign scan_rd = is_zero_reg(32'(scan_idx), RSVD) ? '0 : mem[scan_idx];

  regfile_dbg_scan #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (dbg_start),
    .rd_idx  (scan_idx),
    .rd_data (scan_rd),
    .valid   (dbg_valid),
    .idx     (dbg_idx),
    .data    (dbg_data),
    .done    (dbg_done)
  );

endmodule
